dbus_ram_responder: RTL
=======================

# dbus_ram_responder

Single-port RAM responder for the CPU data-bus master (the dcyc/dstb/dack protocol). It accepts byte, half-word, word and double-word accesses, steers them onto 64-bit memory lanes, and sign- or zero-extends read data. It acknowledges each access with a one-cycle `dack_o` after a programmable number of wait states. It sits behind the system address decoder as on-chip scratch/data memory.

## Interface
Parameters:
- `DEPTH_LOG2`, default 9: memory holds 2^DEPTH_LOG2 64-bit words (512 words = 4 KiB).
- `WAIT_STATES`, default 0: extra cycles between request capture and `dack_o`; 0..15.

Ports:
- `clk_i`  in  1  system clock; all state changes on its rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `dcyc_i`  in  1  bus cycle in progress.
- `dstb_i`  in  1  transfer strobe; a request is `dcyc_i & dstb_i`.
- `dwe_i`  in  1  1 = write, 0 = read.
- `dsiz_i`  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
- `dsigned_i`  in  1  sign-extend read data (ignored for dword and for writes).
- `dadr_i`  in  64  byte address; bits [DEPTH_LOG2+2:3] select the word, bits [2:0] select the lane; upper bits are ignored (aliasing).
- `ddat_i`  in  64  write data, right-justified.
- `ddat_o`  out  64  read data, right-justified and extended; 0 whenever `dack_o`=0.
- `dack_o`  out  1  one-cycle acknowledge.
- `derr_o`  out  1  misaligned access; valid only with `dack_o`.

## Operation
- FSM states: IDLE, WAIT, ACK. Reset forces IDLE with `dack_o`=0, `derr_o`=0, `ddat_o`=0 and the wait counter at 0. Memory contents are not cleared.
- IDLE: if a request is present, go to WAIT with the counter loaded to WAIT_STATES-1, or go straight to ACK when WAIT_STATES=0.
- WAIT: if the request drops, go to IDLE with no memory operation and no ack. Otherwise decrement; on the edge where the counter is 0, go to ACK.
- Memory operation happens on the edge that enters ACK, using the live bus inputs, which the master holds stable until ack. The same edge registers the size, signed flag, lane `dadr_i[2:0]` and the error flag for formatting.
- Misaligned: the lane is not a multiple of the size (half: bit 0; word: bits 1:0; dword: bits 2:0). The access is still acknowledged with `derr_o`=1 and `ddat_o`=0, and no memory write occurs.
- Write: byte enables cover lanes [lane, lane+size-1]. Data `ddat_i` is shifted left by 8·lane. Other bytes in the word are unchanged.
- Read: the word is shifted right by 8·lane and masked to the size. The result is sign-extended from bit 7/15/31 when `dsigned_i`=1, otherwise zero-extended.
- ACK: drive `dack_o`=1 for exactly one cycle, then return to IDLE unconditionally. A request still present in the following IDLE cycle is treated as a new access.

## Timing
- Request visible in cycle c → `dack_o` high in cycle c+1+WAIT_STATES, with `ddat_o`/`derr_o` valid in that same cycle.
- Back-to-back accesses: minimum 2+WAIT_STATES cycles per access, because IDLE is always visited between accesses.
- Write becomes visible to a read issued in any later access.
- Reset asserted mid-WAIT or mid-ACK: next cycle is IDLE with all outputs 0. A write pending in WAIT is not performed.
- Request dropped in the ACK cycle: no effect, since the operation is already complete.

## Structure
- Shared package `polaris_dbus_pkg`: size encodings (SIZ_BYTE/HALF/WORD/DWORD) and the FSM state enumeration.
- Sub-module `dbus_lane_fmt` (combinational): from size, lane and signed it produces the 8-bit byte-enable, the write-data shift, the read extract/extend, and the misalign flag.
- Memory: inferred synchronous-read RAM with per-byte write enables.

## Test plan
- Reset, then dword write 0x0123_4567_89AB_CDEF @0x10, then dword read @0x10 → `dack_o` pulse in cycle c+1 (WAIT_STATES=0), `ddat_o`=0x0123456789ABCDEF, `derr_o`=0.
- Byte write 0x80 @0x13, then signed byte read @0x13 → 0xFFFF_FFFF_FFFF_FF80; unsigned read → 0x80; dword read @0x10 → 0x0123_4567_80AB_CDEF.
- Half read @0x11 → `derr_o`=1, `ddat_o`=0. A half write @0x11 then dword read @0x10 shows the word unchanged.
- WAIT_STATES=3: read request in cycle c → `dack_o` only in cycle c+4; dropping `dstb_i` in cycle c+2 → no ack, FSM back in IDLE, and a write in that position leaves memory unchanged.
- Request held high across ack → second ack two cycles after the first. Reset asserted in WAIT → IDLE next cycle, no ack, no write.
- Address 0x10 + 2^(DEPTH_LOG2+3) aliases to word 2: a write there is read back at 0x10.

Source files
------------

// File: rtl/polaris_dbus_pkg.sv
// rtl/polaris_dbus_pkg.sv - shared encodings for the dcyc/dstb/dack data bus
package polaris_dbus_pkg;

    typedef enum logic [1:0] {
        SIZ_BYTE  = 2'b00,
        SIZ_HALF  = 2'b01,
        SIZ_WORD  = 2'b10,
        SIZ_DWORD = 2'b11
    } siz_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/dbus_ram_responder_if.sv
// rtl/dbus_ram_responder_if.sv - data-bus signal bundle between CPU master and memory responder
interface dbus_ram_responder_if;
    logic        dcyc_i;
    logic        dstb_i;
    logic        dwe_i;
    logic [1:0]  dsiz_i;
    logic        dsigned_i;
    logic [63:0] dadr_i;
    logic [63:0] ddat_i;
    logic [63:0] ddat_o;
    logic        dack_o;
    logic        derr_o;

    modport master (
        output dcyc_i, dstb_i, dwe_i, dsiz_i, dsigned_i, dadr_i, ddat_i,
        input  ddat_o, dack_o, derr_o
    );

    modport slave (
        input  dcyc_i, dstb_i, dwe_i, dsiz_i, dsigned_i, dadr_i, ddat_i,
        output ddat_o, dack_o, derr_o
    );
endinterface

// File: rtl/dbus_lane_fmt.sv
// rtl/dbus_lane_fmt.sv - byte-lane steering, read extension and misalign detection
module dbus_lane_fmt
    import polaris_dbus_pkg::*;
(
    input  siz_e        siz,
    input  logic [2:0]  lane,
    input  logic        sgn,
    input  logic [63:0] wdata,
    input  logic [63:0] rword,
    output logic [7:0]  be,
    output logic [63:0] wdata_sh,
    output logic [63:0] rdata,
    output logic        misalign
);
    logic [63:0] rshift;

    always_comb begin
        be       = 8'h00;
        misalign = 1'b0;
        rdata    = '0;
        rshift   = rword >> {lane, 3'b000};
        wdata_sh = wdata << {lane, 3'b000};
        case (siz)
            SIZ_BYTE: begin
                be    = 8'h01 << lane;
                rdata = sgn ? {{56{rshift[7]}}, rshift[7:0]} : {56'd0, rshift[7:0]};
            end
            SIZ_HALF: begin
                misalign = lane[0];
                be       = 8'h03 << lane;
                rdata    = sgn ? {{48{rshift[15]}}, rshift[15:0]} : {48'd0, rshift[15:0]};
            end
            SIZ_WORD: begin
                misalign = |lane[1:0];
                be       = 8'h0F << lane;
                rdata    = sgn ? {{32{rshift[31]}}, rshift[31:0]} : {32'd0, rshift[31:0]};
            end
            default: begin
                misalign = |lane;
                be       = 8'hFF;
                rdata    = rshift;
            end
        endcase
    end
endmodule

// File: rtl/dbus_ram_responder.sv
// rtl/dbus_ram_responder.sv - single-port 64-bit RAM responder with wait states and lane steering
module dbus_ram_responder
    import polaris_dbus_pkg::*;
#(
    parameter int DEPTH_LOG2  = 9,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    dbus_ram_responder_if.slave  bus
);
    logic [63:0] mem [0:(1<<DEPTH_LOG2)-1];

    state_e      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        op_go;
    logic        req;
    logic        ack;
    logic [DEPTH_LOG2-1:0] idx;
    logic        unused_adr;

    siz_e        siz_q;
    logic [2:0]  lane_q;
    logic        sgn_q, we_q, err_q;
    logic [63:0] rd_word;

    siz_e        fmt_siz;
    logic [2:0]  fmt_lane;
    logic        fmt_sgn;
    logic [7:0]  be;
    logic [63:0] wdata_sh, rdata;
    logic        misalign;

    assign req        = bus.dcyc_i & bus.dstb_i;
    assign ack        = (state == ST_ACK);
    assign idx        = bus.dadr_i[DEPTH_LOG2+2:3];
    assign unused_adr = ^bus.dadr_i[63:DEPTH_LOG2+3];

    // Formatter sees live inputs while deciding the access, registered ones while presenting it.
    assign fmt_siz  = ack ? siz_q  : siz_e'(bus.dsiz_i);
    assign fmt_lane = ack ? lane_q : bus.dadr_i[2:0];
    assign fmt_sgn  = ack ? sgn_q  : bus.dsigned_i;

    dbus_lane_fmt u_fmt (
        .siz      (fmt_siz),
        .lane     (fmt_lane),
        .sgn      (fmt_sgn),
        .wdata    (bus.ddat_i),
        .rword    (rd_word),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata    (rdata),
        .misalign (misalign)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_go    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_nx = ST_ACK;
                        op_go    = 1'b1;
                    end else begin
                        state_nx = ST_WAIT;
                        cnt_nx   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nx = ST_ACK;
                    op_go    = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            siz_q   <= SIZ_BYTE;
            lane_q  <= 3'd0;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rd_word <= '0;
        end else if (op_go) begin
            siz_q   <= siz_e'(bus.dsiz_i);
            lane_q  <= bus.dadr_i[2:0];
            sgn_q   <= bus.dsigned_i;
            we_q    <= bus.dwe_i;
            err_q   <= misalign;
            rd_word <= mem[idx];
        end
    end

    // Misaligned writes are acknowledged but never touch the array.
    always_ff @(posedge clk_i) begin
        if (!reset_i && op_go && bus.dwe_i && !misalign) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    assign bus.dack_o = ack;
    assign bus.derr_o = ack & err_q;
    assign bus.ddat_o = (ack && !err_q && !we_q) ? rdata : 64'd0;
endmodule
